// File: rtl/coin_input_conditioner_if.sv
`default_nettype none
// =============================================================================
// Module   : coin_input_conditioner_if
// Brief    : Valid/ready coin stream from the key conditioner to the vending FSM.
// Revision : 1.0
// =============================================================================
interface coin_input_conditioner_if;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       coin_ready;

  modport master (
    output coin_valid,
    output coin_code,
    input  coin_ready
  );

  modport slave (
    input  coin_valid,
    input  coin_code,
    output coin_ready
  );
endinterface
`default_nettype wire

// File: rtl/coin_input_conditioner.sv
`default_nettype none
// =============================================================================
// Module   : coin_input_conditioner
// Brief    : Synchronises, debounces and edge-detects three active-low coin keys
//            and queues the press events onto a one-coin-per-transfer stream.
// Revision : 1.0
// =============================================================================
module coin_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [2:0]               key_n,
  coin_input_conditioner_if.master coin_bus,
  output logic [2:0]               stable,
  output logic [2:0]               pend,
  output logic [7:0]               press_count
);

  localparam logic [CNT_W-1:0] c_cnt_max    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       c_code_none  = 2'b00;
  localparam logic [1:0]       c_code_50    = 2'b01;
  localparam logic [1:0]       c_code_100   = 2'b10;
  localparam logic [1:0]       c_code_200   = 2'b11;

  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] stable_q, stable_d;
  logic [2:0] pend_q, pend_d;
  logic       coin_valid_q, coin_valid_d;
  logic [1:0] coin_code_q, coin_code_d;
  logic [7:0] press_count_q, press_count_d;

  logic [2:0] w_accept;
  logic [2:0] w_press;
  logic [2:0] w_clr;
  logic       w_free;
  logic       w_xfer;

  // Keys are inverted at the first stage so everything downstream is 1=pressed.
  always_comb begin
    sync1_d = ~key_n;
    sync2_d = sync1_q;
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d = '0;
        end else if (cnt_q == c_cnt_max) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign w_accept[i] = (sync2_q[i] != stable_q[i]) && (cnt_q == c_cnt_max);
    end
  endgenerate

  // An accepted change always lands on the synchronised level; a press is one that lands on 1.
  always_comb begin
    stable_d = (stable_q & ~w_accept) | (sync2_q & w_accept);
    w_press  = w_accept & sync2_q;
  end

  assign w_xfer = coin_valid_q & coin_bus.coin_ready;
  assign w_free = ~coin_valid_q | coin_bus.coin_ready;

  always_comb begin
    w_clr        = 3'b000;
    coin_valid_d = coin_valid_q;
    coin_code_d  = coin_code_q;
    if (w_free) begin
      if (pend_q[2]) begin
        coin_valid_d = 1'b1;
        coin_code_d  = c_code_50;
        w_clr        = 3'b100;
      end else if (pend_q[1]) begin
        coin_valid_d = 1'b1;
        coin_code_d  = c_code_100;
        w_clr        = 3'b010;
      end else if (pend_q[0]) begin
        coin_valid_d = 1'b1;
        coin_code_d  = c_code_200;
        w_clr        = 3'b001;
      end else begin
        coin_valid_d = 1'b0;
        coin_code_d  = c_code_none;
      end
    end
    // A new press on the key being loaded this edge must survive the clear.
    pend_d        = (pend_q & ~w_clr) | w_press;
    press_count_d = press_count_q + {7'd0, w_xfer};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      stable_q      <= 3'b000;
      pend_q        <= 3'b000;
      coin_valid_q  <= 1'b0;
      coin_code_q   <= c_code_none;
      press_count_q <= 8'd0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      pend_q        <= pend_d;
      coin_valid_q  <= coin_valid_d;
      coin_code_q   <= coin_code_d;
      press_count_q <= press_count_d;
    end
  end

  assign coin_bus.coin_valid = coin_valid_q;
  assign coin_bus.coin_code  = coin_code_q;
  assign stable              = stable_q;
  assign pend                = pend_q;
  assign press_count         = press_count_q;

  a_code_idle: assert property (@(posedge CLOCK_50) disable iff (reset)
    !coin_valid_q |-> (coin_code_q == c_code_none));

  a_hold: assert property (@(posedge CLOCK_50) disable iff (reset)
    (coin_valid_q && !coin_bus.coin_ready) |=> (coin_valid_q && $stable(coin_code_q)));

endmodule
`default_nettype wire

// File: tb/tb_coin_input_conditioner.sv
`default_nettype none
// =============================================================================
// Module   : tb_coin_input_conditioner
// Brief    : Directed plus randomised stimulus against a history-window model.
// Revision : 1.0
// =============================================================================
module tb_coin_input_conditioner;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic [2:0] stable;
  logic [2:0] pend;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;

  coin_input_conditioner_if bus ();

  coin_input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .key_n       (key_n),
    .coin_bus    (bus),
    .stable      (stable),
    .pend        (pend),
    .press_count (press_count)
  );

  always #10 clk = ~clk;

  // Reference state: per key, bit j of m_hist = pressed level sampled j+1 edges ago.
  logic [31:0] m_hist [3];
  logic [2:0]  m_stable;
  logic [2:0]  m_pend;
  logic        m_valid;
  logic [1:0]  m_code;
  logic [7:0]  m_count;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // A key's debounced level flips once the level seen through the two-stage
  // synchroniser has differed from it for the last N edges in a row.
  task automatic model_step();
    logic [2:0] press;
    logic [2:0] nxt_stable;
    bit         all_diff;
    bit         picked;
    if (reset) begin
      for (int k = 0; k < 3; k++) m_hist[k] = '0;
      m_stable = 3'b000;
      m_pend   = 3'b000;
      m_valid  = 1'b0;
      m_code   = 2'b00;
      m_count  = 8'd0;
    end else begin
      press      = 3'b000;
      nxt_stable = m_stable;
      for (int k = 0; k < 3; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= N; j++) begin
          if (m_hist[k][j] == m_stable[k]) all_diff = 1'b0;
        end
        if (all_diff) begin
          nxt_stable[k] = ~m_stable[k];
          if (!m_stable[k]) press[k] = 1'b1;
        end
      end
      if (m_valid && bus.coin_ready) m_count = m_count + 8'd1;
      if (!m_valid || bus.coin_ready) begin
        picked  = 1'b0;
        m_valid = 1'b0;
        m_code  = 2'b00;
        for (int k = 2; k >= 0; k--) begin
          if (!picked && m_pend[k]) begin
            picked    = 1'b1;
            m_valid   = 1'b1;
            m_code    = 2'(3 - k);
            m_pend[k] = 1'b0;
          end
        end
      end
      m_pend   = m_pend | press;
      m_stable = nxt_stable;
      for (int k = 0; k < 3; k++) m_hist[k] = {m_hist[k][30:0], ~key_n[k]};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("coin_valid",  bus.coin_valid, m_valid);
    check_eq("coin_code",   bus.coin_code,  m_code);
    check_eq("stable",      stable,         m_stable);
    check_eq("pend",        pend,           m_pend);
    check_eq("press_count", press_count,    m_count);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    key_n = 3'b111;
    run(n);
    reset = 1'b0;
  endtask

  int timer [3];

  initial begin
    reset          = 1'b1;
    key_n          = 3'b111;
    bus.coin_ready = 1'b0;

    // Reset state
    run(2);
    check_eq("rst_valid", bus.coin_valid, 0);
    check_eq("rst_code",  bus.coin_code,  0);
    check_eq("rst_stable", stable, 0);
    check_eq("rst_pend",  pend, 0);
    check_eq("rst_count", press_count, 0);
    reset = 1'b0;

    // Single 50 press, latency to the output register
    bus.coin_ready = 1'b1;
    key_n = 3'b011;
    run(6);
    check_eq("t2_valid_e6", bus.coin_valid, 0);
    run(1);
    check_eq("t2_valid_e7", bus.coin_valid, 1);
    check_eq("t2_code_e7",  bus.coin_code,  1);
    run(5);
    key_n = 3'b111;
    run(15);
    check_eq("t2_count", press_count, 1);

    // Bounce shorter than the window
    do_reset(2);
    key_n = 3'b101; run(3);
    key_n = 3'b111; run(1);
    key_n = 3'b101; run(3);
    key_n = 3'b111; run(15);
    check_eq("t3_count", press_count, 0);

    // All keys at once under backpressure
    do_reset(2);
    bus.coin_ready = 1'b0;
    key_n = 3'b000; run(10);
    check_eq("t4_pend",  pend, 3'b011);
    check_eq("t4_valid", bus.coin_valid, 1);
    check_eq("t4_code",  bus.coin_code, 1);
    key_n = 3'b111;
    bus.coin_ready = 1'b1;
    run(10);
    check_eq("t4_count", press_count, 3);
    check_eq("t4_idle",  bus.coin_valid, 0);

    // Third press dropped while pend bit already set
    do_reset(2);
    bus.coin_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      key_n = 3'b011; run(6);
      key_n = 3'b111; run(6);
    end
    bus.coin_ready = 1'b1;
    run(10);
    check_eq("t5_count", press_count, 2);

    // Reset mid-handshake
    do_reset(2);
    bus.coin_ready = 1'b0;
    key_n = 3'b000; run(10);
    reset = 1'b1;
    key_n = 3'b111;
    run(1);
    reset = 1'b0;
    check_eq("t6_valid", bus.coin_valid, 0);
    check_eq("t6_pend",  pend, 0);
    check_eq("t6_count", press_count, 0);
    bus.coin_ready = 1'b1;
    run(12);
    check_eq("t6_after_valid", bus.coin_valid, 0);
    check_eq("t6_after_count", press_count, 0);

    // Randomised keys, readiness and occasional reset
    do_reset(2);
    for (int k = 0; k < 3; k++) timer[k] = $urandom_range(1, N + 4);
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        timer[k]--;
        if (timer[k] <= 0) begin
          key_n[k] = ~key_n[k];
          timer[k] = $urandom_range(1, N + 5);
        end
      end
      bus.coin_ready = ($urandom_range(0, 9) < 6);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
